// File: rtl/out_port_arb.sv
// out_port_arb: per-output-port wormhole arbiter.
// Round-robin grant among RN input buffers; the grant is locked for the whole
// frame and released on the tail flit, on a dropped request, or (when the
// OUT_PORT_ARB_WDT_EN macro is defined) on a watchdog timeout of TO idle cycles.
module out_port_arb #(
  parameter int RN = 4,
  parameter int TO = 255,
  localparam int OW = $clog2(RN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RN-1:0] req,
  input  logic          flit_fire,
  input  logic          eof,
  output logic [RN-1:0] gnt,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          abort
);

  // Elaboration-time parameter legality check
  if (RN < 2 || RN > 8 || TO < 1 || TO > 65535) begin : g_bad_param
    $error("out_port_arb: RN must be 2..8 and TO 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_REL} state_t;

  state_t        r_state, w_state_nxt;
  logic [RN-1:0] r_gnt;
  logic [OW-1:0] r_owner, r_ptr, w_pick;
  logic [15:0]   r_frame_cnt;
  logic          w_found, w_tail, w_drop, w_wdt_to, w_start, w_end;

  assign w_tail = flit_fire & eof;
  assign w_drop = ~req[r_owner];

  // Round-robin pick: first requester at or after r_ptr, wrapping.
  // Scanned from the farthest offset down so the nearest one wins.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int i = RN - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= RN) j = j - RN;
      if (req[j]) begin
        w_found = 1'b1;
        w_pick  = j[OW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; w_start/w_end mark frame entry and release
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) begin
        w_state_nxt = S_XFER;
        w_start     = 1'b1;
      end
      S_XFER: if (w_tail || w_drop || w_wdt_to) begin
        w_state_nxt = S_REL;
        w_end       = 1'b1;
      end
      S_REL:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, owner, round-robin pointer and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_start) begin
        r_gnt   <= {{(RN-1){1'b0}}, 1'b1} << w_pick;
        r_owner <= w_pick;
      end
      if (w_end) r_gnt <= '0;
      // Only a real tail counts; drops and timeouts release silently
      if (r_state == S_XFER && w_tail) r_frame_cnt <= r_frame_cnt + 16'd1;
      // Next search starts just past the last owner
      if (r_state == S_REL)
        r_ptr <= (r_owner == OW'(RN - 1)) ? '0 : r_owner + OW'(1);
    end
  end

`ifdef OUT_PORT_ARB_WDT_EN
  logic [15:0] r_wdt;

  // Idle-cycle counter: cleared on frame entry and every accepted flit
  always_ff @(posedge clk) begin
    if (rst)                       r_wdt <= '0;
    else if (w_start || flit_fire) r_wdt <= '0;
    else if (r_state == S_XFER)    r_wdt <= r_wdt + 16'd1;
  end

  assign w_wdt_to = (r_state == S_XFER) && (r_wdt == 16'(TO));
  // A tail in the same cycle completes the frame normally instead
  assign abort    = w_wdt_to & ~w_tail;
`else
  assign w_wdt_to = 1'b0;
  assign abort    = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign owner     = r_owner;
  assign busy      = (r_state == S_XFER);
  assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/out_port_arb.md
OUT_PORT_ARB -- requirements
Module: out_port_arb

Interface
REQ-001 Parameter RN, default 4: number of requesting input buffers; legal range 2..8.
REQ-002 Parameter TO, default 255: watchdog limit in idle cycles; legal range 1..65535; used only when OUT_PORT_ARB_WDT_EN is defined.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  RN  per-input route request (the arb_r bit for this output port), level-held for the whole frame.
REQ-007 flit_fire  input  1  one flit accepted by this output port this cycle.
REQ-008 eof  input  1  the flit qualified by flit_fire is the tail flit.
REQ-009 gnt  output  RN  one-hot grant, registered; doubles as arb_ra for the owner.
REQ-010 owner  output  $clog2(RN)  index of the current or last owner, registered.
REQ-011 busy  output  1  high while in state XFER.
REQ-012 frame_cnt  output  16  count of frames completed with a tail flit; wraps.
REQ-013 abort  output  1  one-cycle pulse on a watchdog release.

Function
REQ-014 The FSM SHALL have states IDLE, XFER and REL, encoded in a registered state variable.
REQ-015 IDLE: if req!=0 at edge t, the FSM SHALL select the first set bit at or after ptr in ascending, wrapping order; gnt SHALL be set and state SHALL be XFER from t+1.
REQ-016 IDLE with req==0 SHALL remain in IDLE with gnt=0.
REQ-017 XFER: gnt and owner SHALL hold constant regardless of other req bits (wormhole lock).
REQ-018 XFER with flit_fire&eof at edge t: gnt SHALL be 0 and state SHALL be REL from t+1, and frame_cnt SHALL increment by 1 mod 2^16.
REQ-019 XFER with req[owner]==0 and no flit_fire&eof (route error or drop): the FSM SHALL go to REL, and frame_cnt SHALL NOT increment.
REQ-020 REL SHALL last exactly one cycle: ptr SHALL be set to (owner+1) mod RN, then the FSM SHALL go to IDLE; a new grant appears no earlier than 3 cycles after the tail edge.
REQ-021 eof without flit_fire SHALL be ignored; flit_fire or eof in IDLE or REL SHALL be ignored.
REQ-022 gnt SHALL be one-hot or zero in every cycle; busy SHALL equal (state==XFER).
REQ-023 Round-robin fairness: with all req held high, successive owners SHALL be 0,1,..,RN-1,0,...

Reset
REQ-024 When rst is high at an edge, the following SHALL hold from the next cycle: state=IDLE, gnt=0, owner=0, ptr=0, busy=0, frame_cnt=0, abort=0, watchdog=0; this applies mid-frame and overrides all other inputs.
REQ-025 While rst is high, no grant SHALL be issued.

Configuration
REQ-026 Macro OUT_PORT_ARB_WDT_EN defined: a 16-bit counter SHALL clear on entry to XFER and on every flit_fire, and increment on other XFER cycles; when it reaches TO, abort SHALL pulse for one cycle, the FSM SHALL go to REL, and frame_cnt SHALL NOT increment.
REQ-027 Macro OUT_PORT_ARB_WDT_EN undefined: no watchdog logic SHALL exist, abort SHALL be tied to 0, and TO SHALL be unused.

Verification
REQ-028 rst, then req=4'b0100 at cycle 2 -> gnt=4'b0100, owner=2, busy=1 at cycle 3.
REQ-029 req=4'b1111 held, 3 flits per frame with eof on the 3rd -> owner sequence 0,1,2,3,0; frame_cnt=5; gnt low for 2 cycles between frames.
REQ-030 Owner 1 in XFER, req[3] rises mid-frame -> gnt stays 4'b0010 until the tail; the next grant is 4'b1000.
REQ-031 Owner 0 drops req[0] with no eof -> REL then IDLE; frame_cnt unchanged.
REQ-032 WDT_EN, TO=8, owner stalls with no flit_fire -> abort pulses 8 cycles after the last fire, gnt=0 the next cycle; without the macro, abort=0 and gnt holds.
REQ-033 rst asserted during XFER with frame_cnt=7 -> next cycle gnt=0, frame_cnt=0, owner=0; after release, req=4'b0001 -> grant 0.
